// File: rtl/stepper_pkg.sv
// Shared types for the stepper sequencer: FSM states and the command
// direction / step-mode encodings.
package stepper_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        DIR_REV = 1'b0,
        DIR_FWD = 1'b1
    } dir_t;

    typedef enum logic {
        MODE_FULL = 1'b0,
        MODE_HALF = 1'b1
    } mode_t;

endpackage

// File: rtl/stepper_phase_decode.sv
// Maps the half-phase index h onto the coil pattern: even h energises one
// coil, odd h energises the two neighbouring coils.
module stepper_phase_decode #(
    parameter int PHASES = 4,
    parameter int H_W    = $clog2(2 * PHASES)
) (
    input  logic [H_W-1:0]    h,
    output logic [PHASES-1:0] pattern
);

    logic [H_W-1:0] lo;
    logic [H_W-1:0] hi;

    always_comb begin
        lo      = h >> 1;
        hi      = (lo == H_W'(PHASES - 1)) ? '0 : lo + H_W'(1);
        pattern = '0;
        for (int i = 0; i < PHASES; i++) begin
            pattern[i] = (lo == H_W'(i)) || (h[0] && (hi == H_W'(i)));
        end
    end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Stepper-motor move sequencer: accepts a move command, walks the coil
// pattern at a fixed step rate, tracks position and pulses done at the end.
import stepper_pkg::*;

module stepper_seq_ctrl #(
    parameter int PHASES   = 4,
    parameter int POS_W    = 8,
    parameter int RATE_DIV = 2
) (
    input  logic              drv_clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic              cmd_half,
    input  logic [POS_W-1:0]  cmd_steps,
    input  logic              abort,
    output logic [PHASES-1:0] motor_drv,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);

    localparam int HSTEPS = 2 * PHASES;
    localparam int H_W    = $clog2(HSTEPS);
    localparam int RC_W   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RATE_DIV - 1);
    localparam logic [H_W:0]    HSTEPS_X = (H_W + 1)'(HSTEPS);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    mode_t            mode_q, mode_d;
    logic [RC_W-1:0]  rate_q, rate_d;
    logic [POS_W-1:0] rem_q, rem_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [H_W-1:0]   h_q, h_d;
    logic             done_q, done_d;
    logic [PHASES-1:0] pattern;

    // One extra bit of headroom keeps the modular add/subtract overflow-free.
    function automatic logic [H_W-1:0] next_h(input logic [H_W-1:0] h,
                                              input dir_t dir,
                                              input mode_t mode);
        logic [H_W:0] amt;
        logic [H_W:0] hx;
        logic [H_W:0] res;
        amt = (mode == MODE_HALF) ? (H_W + 1)'(1) : (H_W + 1)'(2);
        hx  = {1'b0, h};
        if (dir == DIR_FWD) begin
            res = hx + amt;
            if (res >= HSTEPS_X) res = res - HSTEPS_X;
        end else begin
            res = (hx >= amt) ? hx - amt : hx + HSTEPS_X - amt;
        end
        return res[H_W-1:0];
    endfunction

    always_ff @(posedge drv_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_REV;
            mode_q  <= MODE_FULL;
            rate_q  <= '0;
            rem_q   <= '0;
            pos_q   <= '0;
            h_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            h_q     <= h_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        rate_d  = rate_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        h_d     = h_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_RUN;
                    dir_d   = dir_t'(cmd_dir);
                    mode_d  = mode_t'(cmd_half);
                    rem_d   = cmd_steps;
                    rate_d  = '0;
                end
            end
            ST_RUN: begin
                // Abort wins over any step due on the same edge, even the last one.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rem_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (rate_q == RC_LAST) begin
                    rate_d = '0;
                    h_d    = next_h(h_q, dir_q, mode_q);
                    pos_d  = (dir_q == DIR_FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    rem_d  = rem_q - POS_W'(1);
                    if (rem_q == POS_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    rate_d = rate_q + RC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    stepper_phase_decode #(
        .PHASES (PHASES),
        .H_W    (H_W)
    ) u_decode (
        .h       (h_q),
        .pattern (pattern)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign motor_drv = busy ? pattern : '0;
    assign done      = done_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Scoreboard bench for stepper_seq_ctrl: each accepted move pushes its
// expected coil trace and end state; a negedge monitor consumes them.
module tb_stepper_seq_ctrl;

    localparam int PH = 4;
    localparam int PW = 8;
    localparam int R  = 2;

    logic          drv_clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic          cmd_half;
    logic [PW-1:0] cmd_steps;
    logic          abort;
    logic [PH-1:0] motor_drv;
    logic          busy;
    logic          done;
    logic [PW-1:0] position;

    stepper_seq_ctrl #(
        .PHASES   (PH),
        .POS_W    (PW),
        .RATE_DIV (R)
    ) dut (
        .drv_clk   (drv_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_half  (cmd_half),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .motor_drv (motor_drv),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 drv_clk = ~drv_clk;

    typedef struct {
        bit   exp_done;
        int   exp_pos;
        int   exp_len;
    } end_t;

    end_t          end_q[$];
    logic [PH-1:0] drv_q[$];

    int checks = 0;
    int errors = 0;
    int m_h    = 0;
    int m_pos  = 0;
    bit mon_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int wrap(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    // Coil pattern for half-phase index h, straight from the stepping rule.
    function automatic logic [PH-1:0] pat(input int h);
        logic [PH-1:0] p;
        p = '0;
        p[h / 2] = 1'b1;
        if (h % 2 == 1) p[(h / 2 + 1) % PH] = 1'b1;
        return p;
    endfunction

    task automatic model_accept(input bit dir, input bit half, input int steps, input int abort_at);
        int   sgn;
        int   sz;
        int   applied;
        int   len;
        end_t e;
        sgn = dir ? 1 : -1;
        sz  = half ? 1 : 2;
        if (abort_at > 0) begin
            applied = (abort_at - 1) / R;
            len     = abort_at;
        end else begin
            applied = steps;
            len     = (steps == 0) ? 1 : steps * R;
        end
        for (int j = 0; j < len; j++) drv_q.push_back(pat(wrap(m_h + sgn * sz * (j / R), 2 * PH)));
        m_h   = wrap(m_h + sgn * sz * applied, 2 * PH);
        m_pos = wrap(m_pos + sgn * applied, 1 << PW);
        e.exp_done = (abort_at == 0);
        e.exp_pos  = m_pos;
        e.exp_len  = len;
        end_q.push_back(e);
    endtask

    task automatic send(input bit dir, input bit half, input int steps, input int abort_at, input bit hold);
        int waited;
        waited    = 0;
        cmd_dir   = dir;
        cmd_half  = half;
        cmd_steps = PW'(steps);
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 300) begin
            @(posedge drv_clk); #1;
            waited++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        model_accept(dir, half, steps, abort_at);
        @(posedge drv_clk); #1;
        cmd_valid = hold;
        if (abort_at > 0) begin
            repeat (abort_at - 1) begin
                @(posedge drv_clk); #1;
            end
            abort = 1'b1;
            @(posedge drv_clk); #1;
            abort = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (end_q.size() != 0 && n < 500) begin
            @(posedge drv_clk); #1;
            n++;
        end
        chk("drain_end_q", end_q.size(), 0);
        chk("drain_drv_q", drv_q.size(), 0);
    endtask

    bit            prev_busy = 1'b0;
    int            blen      = 0;
    end_t          mon_e;
    logic [PH-1:0] mon_drv;

    always @(negedge drv_clk) begin
        if (!mon_en) begin
            prev_busy = 1'b0;
            blen      = 0;
        end else begin
            if (busy) begin
                blen++;
                if (drv_q.size() == 0) begin
                    chk("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    mon_drv = drv_q.pop_front();
                    chk("motor_drv_run", {28'd0, motor_drv}, {28'd0, mon_drv});
                end
            end else begin
                chk("motor_drv_idle", {28'd0, motor_drv}, 32'd0);
            end
            if (prev_busy && !busy) begin
                if (end_q.size() == 0) begin
                    chk("unexpected_end", 32'd1, 32'd0);
                end else begin
                    mon_e = end_q.pop_front();
                    chk("done_at_end", {31'd0, done}, {31'd0, mon_e.exp_done});
                    chk("position_end", {24'd0, position}, mon_e.exp_pos);
                    chk("busy_cycles", blen, mon_e.exp_len);
                end
                blen = 0;
            end else if (done) begin
                chk("spurious_done", 32'd1, 32'd0);
            end
            prev_busy = busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        int ab;
        bit hold;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_half  = 1'b0;
        cmd_steps = '0;
        abort     = 1'b0;
        repeat (3) @(posedge drv_clk);
        #1;
        reset = 1'b0;
        chk("rst_motor_drv", {28'd0, motor_drv}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_position", {24'd0, position}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        mon_en = 1'b1;

        send(1'b1, 1'b0, 4, 0, 1'b0);
        drain();
        send(1'b0, 1'b1, 3, 0, 1'b0);
        drain();
        send(1'b1, 1'b0, 0, 0, 1'b0);
        drain();
        send(1'b1, 1'b0, 5, 5, 1'b0);
        drain();
        send(1'b1, 1'b0, 5, 10, 1'b0);
        drain();
        // abort while idle must do nothing
        abort = 1'b1;
        @(posedge drv_clk); #1;
        abort = 1'b0;
        send(1'b1, 1'b1, 3, 0, 1'b1);
        send(1'b0, 1'b0, 2, 0, 1'b0);
        drain();

        send(1'b1, 1'b1, 6, 0, 1'b0);
        repeat (3) begin
            @(posedge drv_clk); #1;
        end
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge drv_clk); #1;
        reset = 1'b0;
        chk("midrst_motor_drv", {28'd0, motor_drv}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_position", {24'd0, position}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        drv_q.delete();
        end_q.delete();
        m_h   = 0;
        m_pos = 0;
        @(posedge drv_clk); #1;
        mon_en = 1'b1;

        send(1'b0, 1'b0, 1, 0, 1'b0);
        send(1'b1, 1'b1, 1, 0, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            steps = $urandom_range(0, 12);
            ab    = 0;
            if (steps > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, steps * R);
            hold = (ab == 0) && (i != 39) && ($urandom_range(0, 1) == 1);
            send($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, steps, ab, hold);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_seq_ctrl.md
# stepper_seq_ctrl

Parametrised stepper-motor sequencer and the successor to the fixed 4-phase forward/reverse drive FSM. It accepts a move command through a valid/ready handshake. The command gives direction, step count and full/half-step mode. The block then walks a PHASES-wide coil pattern at a programmable step rate, tracks absolute position, and pulses `done` on completion. It sits between the motion-control logic and the coil drivers.

## Interface
Parameters:
- PHASES, default 4: number of coil phases. Legal range is PHASES ≥ 3.
- POS_W, default 8: width of the step count and the position counter.
- RATE_DIV, default 2: number of drv_clk cycles per step. Legal range is RATE_DIV ≥ 1.

Ports (reset is synchronous, active-high; clock is drv_clk):
- drv_clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_half  in  1  1 = half-step mode, 0 = full-step mode
- cmd_steps  in  POS_W  number of steps to move
- abort  in  1  stop the current move immediately
- motor_drv  out  PHASES  coil drive pattern
- busy  out  1  move in progress
- done  out  1  one-cycle pulse when a move completes
- position  out  POS_W  signed-wrap step position

## Operation
- States:
  - IDLE: cmd_ready=1.
  - RUN: cmd_ready=0.
- Half-phase index h is a register in 0..2·PHASES-1.
  - Even h: drive the single bit h/2.
  - Odd h: drive bits (h-1)/2 and ((h+1)/2) mod PHASES.
- motor_drv equals pattern(h) while busy, and 0 in IDLE.
- Step size on h:
  - Full-step: ±2 mod 2·PHASES. Parity of h is preserved, so an odd h gives two-phase-on full stepping.
  - Half-step: ±1 mod 2·PHASES.
  - Forward is +, reverse is −.
- position changes by ±1 per step event in either mode and wraps modulo 2^POS_W.
- Acceptance: cmd_valid & cmd_ready at a drv_clk edge.
  - Latches dir, half and steps into `remaining`.
  - Clears the rate counter.
  - Enters RUN; busy=1.
- In RUN, the rate counter counts 0..RATE_DIV-1. When it reaches RATE_DIV-1, one step is applied: h and position update, and remaining decrements.
  - If remaining reaches 0 on that step: go to IDLE, busy=0, done=1 for one cycle.
- cmd_steps=0: the command is accepted, then done pulses at the next edge with no motion. motor_drv is pattern(h) for that single cycle.
- abort in RUN:
  - Go to IDLE at the next edge with no done pulse.
  - h and position hold their current values.
  - Abort takes priority over a coincident step, including the final one; that step is not applied.
- abort in IDLE is ignored.
- cmd_valid while in RUN is ignored; it is not queued.
- reset, including mid-move, clears everything at the next edge: state=IDLE, h=0, position=0, motor_drv=0, busy=0, done=0. reset takes priority over abort and commands.

## Timing
- Reset values: motor_drv=0, busy=0, done=0, position=0. cmd_ready=1 after reset.
- All state is registered. cmd_ready is combinational: (state==IDLE).
- A command accepted at edge k:
  - Step i (1..N) takes effect at edge k+i·RATE_DIV.
  - done is high in the cycle following edge k+N·RATE_DIV, and busy falls at that same edge.
- In the done cycle the state is already IDLE, so a new command can be accepted at that edge. Back-to-back moves therefore have no gap.

## Structure
- Shared package stepper_pkg holds the state enum (ST_IDLE, ST_RUN) and the dir/mode encodings.
- One sub-module, stepper_phase_decode, is parametrised by PHASES and maps h to motor_drv.
- The main module holds the FSM, rate counter, remaining counter, h and position.

## Test plan
All cases use PHASES=4, RATE_DIV=2, POS_W=8.
1. Reset, then a forward full-step move of 4 steps from h=0.
   - motor_drv: 0001, 0010, 0100, 1000, 0001, changing every 2 cycles.
   - position ends at 4; done pulses once, 8 cycles after acceptance.
2. Reverse half-step move of 3 steps from h=0.
   - motor_drv: 0001, 1001, 1000, 1100.
   - position goes 0, 255, 254, 253.
3. cmd_steps=0.
   - done pulses in the next cycle; position is unchanged; busy lasts 1 cycle.
4. Forward move of 5 steps with abort asserted after step 2, and a second run with abort coincident with step 5.
   - No done pulse; busy=0 next cycle.
   - Position is 2 in the first run and 4 in the second.
5. cmd_valid held high through a move.
   - Ignored during RUN.
   - A second command is accepted in the done cycle and its first step follows 2 cycles later.
6. Wrap and mid-move reset.
   - From position=255, a forward move of 1 step gives position=0.
   - reset asserted mid-move: the next cycle shows motor_drv=0, busy=0, position=0, done=0.
